bus_rr_arbiter: RTL and testbench

- Shares one simple valid/ready byte bus (data/valid/ready) between N_REQ producer-side requesters and a single consumer.
- Round-robin arbitration with bounded burst ownership.
- One-entry registered output stage, so out_data/out_valid come straight from flops.
- Sits between multiple producers and a consumer in the bus test designs; exposes grant state and a transfer counter for checksum/debug.

---
 rtl/bus_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_rr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready byte bus between N_REQ producers,
// with bounded burst ownership and a registered one-entry output stage.
module bus_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [31:0]              xfer_count
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int IDX_W = ID_W + 1;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE,
        OWN
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [31:0]        xfer_count_q, xfer_count_d;

    logic               load_slot;
    logic               owner_keep;
    logic               scan_hit;
    logic [ID_W-1:0]    scan_id;
    logic [IDX_W-1:0]   scan_idx;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic               accept;

    // Rotating priority scan starting at ptr_q, wrapping modulo N_REQ.
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated value; every variable gets a default first so no latch is inferred.
    always_comb begin
        scan_hit = 1'b0;
        scan_id  = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + IDX_W'(k);
            if (scan_idx >= IDX_W'(N_REQ)) begin
                scan_idx = scan_idx - IDX_W'(N_REQ);
            end
            if (!scan_hit && req_valid[scan_idx[ID_W-1:0]]) begin
                scan_hit = 1'b1;
                scan_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        load_slot  = !out_valid_q || out_ready;
        owner_keep = (state_q == OWN) && req_valid[grant_id_q]
                     && (beat_cnt_q < CNT_W'(MAX_BURST));
        win_valid  = owner_keep || scan_hit;
        win_id     = owner_keep ? grant_id_q : scan_id;
        accept     = !rst && load_slot && win_valid;
        req_ready  = accept ? (N_REQ'(1) << win_id) : '0;
    end

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        ptr_d        = ptr_q;
        beat_cnt_d   = beat_cnt_q;
        xfer_count_d = xfer_count_q + ((out_valid_q && out_ready) ? 32'd1 : 32'd0);

        if (load_slot) begin
            if (accept) begin
                out_data_d  = req_data[win_id*DATA_W +: DATA_W];
                out_valid_d = 1'b1;
                grant_d     = N_REQ'(1) << win_id;
                grant_id_d  = win_id;
                state_d     = OWN;
                // A fresh tenure (new owner, from idle, or forced re-win) restarts at 1.
                beat_cnt_d  = owner_keep ? beat_cnt_q + CNT_W'(1) : CNT_W'(1);
                ptr_d       = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
            end else begin
                out_valid_d = 1'b0;
                grant_d     = '0;
                state_d     = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all flops update together;
    // reset here is synchronous, matching the rest of the bus test designs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            grant_q      <= '0;
            grant_id_q   <= '0;
            ptr_q        <= '0;
            beat_cnt_q   <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            grant_q      <= grant_d;
            grant_id_q   <= grant_id_d;
            ptr_q        <= ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: one DUT with MAX_BURST=4 and a second
// with MAX_BURST=1 sharing clock, reset, data and consumer ready.
module tb_bus_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid  = '0;
    logic [3:0]  req_valid1 = '0;
    logic [31:0] req_data   = '0;
    logic        out_ready  = 1'b0;

    logic [3:0]  req_ready,  req_ready1;
    logic [7:0]  out_data,   out_data1;
    logic        out_valid,  out_valid1;
    logic [3:0]  grant,      grant1;
    logic [1:0]  grant_id,   grant_id1;
    logic [31:0] xfer_count, xfer_count1;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .grant(grant), .grant_id(grant_id),
        .xfer_count(xfer_count)
    );

    bus_rr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_data(req_data),
        .req_ready(req_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .grant(grant1), .grant_id(grant_id1),
        .xfer_count(xfer_count1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_valid1 = '0;
        out_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h4342_4140;
        out_ready = 1'b0;
        tick();
        vec_cnt++;
        if (req_ready !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_ready: got %b exp 0000", req_ready);
        end
        tick();
        vec_cnt++;
        if ({out_valid, out_data, grant, grant_id, xfer_count} !== {1'b0, 8'h00, 4'b0000, 2'd0, 32'd0}) begin
            err_cnt++;
            $display("FAIL reset_state: got v=%b d=%h g=%b id=%0d x=%0d exp all zero",
                     out_valid, out_data, grant, grant_id, xfer_count);
        end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            req_valid = 4'b0001;
            req_data  = {24'h0, 8'(i)};
            #1;
            vec_cnt++;
            if (req_ready !== 4'b0001) begin
                err_cnt++;
                $display("FAIL single_ready[%0d]: got %b exp 0001", i, req_ready);
            end
            tick();
            vec_cnt++;
            if ({out_valid, out_data, grant, grant_id} !== {1'b1, 8'(i), 4'b0001, 2'd0}) begin
                err_cnt++;
                $display("FAIL single_out[%0d]: got v=%b d=%h g=%b id=%0d exp v=1 d=%h g=0001 id=0",
                         i, out_valid, out_data, grant, grant_id, 8'(i));
            end
        end
        req_valid = '0;
        tick();
        vec_cnt++;
        if ({out_valid, out_data, grant, xfer_count} !== {1'b0, 8'h06, 4'b0000, 32'd6}) begin
            err_cnt++;
            $display("FAIL single_drain: got v=%b d=%h g=%b x=%0d exp v=0 d=06 g=0000 x=6",
                     out_valid, out_data, grant, xfer_count);
        end
    endtask

    task automatic test_two_way();
        logic [1:0] exp_id;
        do_reset();
        out_ready = 1'b1;
        req_data  = 32'h0000_B1A0;
        req_valid = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            exp_id = 2'((i / 4) % 2);
            #1;
            vec_cnt++;
            if (req_ready !== (4'b0001 << exp_id)) begin
                err_cnt++;
                $display("FAIL two_way_ready[%0d]: got %b exp %b", i, req_ready, 4'b0001 << exp_id);
            end
            tick();
            vec_cnt++;
            if ({grant_id, out_data} !== {exp_id, (exp_id == 2'd0) ? 8'hA0 : 8'hB1}) begin
                err_cnt++;
                $display("FAIL two_way_owner[%0d]: got id=%0d d=%h exp id=%0d", i, grant_id, out_data, exp_id);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0001;
        req_data  = 32'h0000_002A;
        tick();
        req_data  = 32'h0000_002B;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vec_cnt++;
            if (req_ready !== 4'b0000) begin
                err_cnt++;
                $display("FAIL bp_ready[%0d]: got %b exp 0000", i, req_ready);
            end
            tick();
            vec_cnt++;
            if ({out_valid, out_data, grant, xfer_count} !== {1'b1, 8'h2A, 4'b0001, 32'd0}) begin
                err_cnt++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h g=%b x=%0d exp v=1 d=2a g=0001 x=0",
                         i, out_valid, out_data, grant, xfer_count);
            end
        end
        out_ready = 1'b1;
        #1;
        vec_cnt++;
        if (req_ready !== 4'b0001) begin
            err_cnt++;
            $display("FAIL bp_refill_ready: got %b exp 0001", req_ready);
        end
        tick();
        vec_cnt++;
        if ({out_valid, out_data, xfer_count} !== {1'b1, 8'h2B, 32'd1}) begin
            err_cnt++;
            $display("FAIL bp_refill: got v=%b d=%h x=%0d exp v=1 d=2b x=1", out_valid, out_data, xfer_count);
        end
        req_valid = '0;
        tick();
        vec_cnt++;
        if ({out_valid, xfer_count} !== {1'b0, 32'd2}) begin
            err_cnt++;
            $display("FAIL bp_drain: got v=%b x=%0d exp v=0 x=2", out_valid, xfer_count);
        end
    endtask

    task automatic test_owner_drop();
        logic [3:0] valid_tab [7] = '{4'b1100, 4'b1100, 4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1100};
        logic [1:0] exp_tab   [7] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2};
        do_reset();
        out_ready = 1'b1;
        req_data  = 32'h4342_4140;
        for (int i = 0; i < 7; i++) begin
            req_valid = valid_tab[i];
            tick();
            vec_cnt++;
            if ({out_valid, grant_id, grant, out_data} !==
                {1'b1, exp_tab[i], 4'b0001 << exp_tab[i], 8'h40 + 8'(exp_tab[i])}) begin
                err_cnt++;
                $display("FAIL drop_owner[%0d]: got v=%b id=%0d g=%b d=%h exp id=%0d",
                         i, out_valid, grant_id, grant, out_data, exp_tab[i]);
            end
        end
        req_valid = '0;
        tick();
        vec_cnt++;
        if ({out_valid, grant, out_data} !== {1'b0, 4'b0000, 8'h42}) begin
            err_cnt++;
            $display("FAIL drop_idle: got v=%b g=%b d=%h exp v=0 g=0000 d=42", out_valid, grant, out_data);
        end
    endtask

    task automatic test_burst1_rotation();
        logic [1:0] exp_id;
        do_reset();
        out_ready  = 1'b1;
        req_data   = 32'h4342_4140;
        req_valid1 = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            exp_id = 2'(i % 4);
            tick();
            vec_cnt++;
            if ({grant1, grant_id1, out_data1} !== {4'b0001 << exp_id, exp_id, 8'h40 + 8'(exp_id)}) begin
                err_cnt++;
                $display("FAIL mb1_order[%0d]: got g=%b id=%0d d=%h exp id=%0d",
                         i, grant1, grant_id1, out_data1, exp_id);
            end
        end
        req_valid1 = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        req_data  = 32'h4342_4140;
        req_valid = 4'b0010;
        #1;
        vec_cnt++;
        if (req_ready !== 4'b0010) begin
            err_cnt++;
            $display("FAIL rmid_ready: got %b exp 0010", req_ready);
        end
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        vec_cnt++;
        if ({out_valid, grant, xfer_count} !== {1'b1, 4'b0010, 32'd1}) begin
            err_cnt++;
            $display("FAIL rmid_pre: got v=%b g=%b x=%0d exp v=1 g=0010 x=1", out_valid, grant, xfer_count);
        end
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        vec_cnt++;
        if (req_ready !== 4'b0000) begin
            err_cnt++;
            $display("FAIL rmid_rst_ready: got %b exp 0000", req_ready);
        end
        tick();
        vec_cnt++;
        if ({out_valid, grant, grant_id, xfer_count} !== {1'b0, 4'b0000, 2'd0, 32'd0}) begin
            err_cnt++;
            $display("FAIL rmid_rst: got v=%b g=%b id=%0d x=%0d exp all zero",
                     out_valid, grant, grant_id, xfer_count);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        vec_cnt++;
        if (req_ready !== 4'b0001) begin
            err_cnt++;
            $display("FAIL rmid_first_ready: got %b exp 0001", req_ready);
        end
        tick();
        vec_cnt++;
        if ({out_valid, grant, out_data} !== {1'b1, 4'b0001, 8'h40}) begin
            err_cnt++;
            $display("FAIL rmid_first: got v=%b g=%b d=%h exp v=1 g=0001 d=40", out_valid, grant, out_data);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_two_way();
        test_backpressure();
        test_owner_drop();
        test_burst1_rotation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
